// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   - arb_state_e : arbiter FSM states (IDLE, SEND, WAIT, HOLD)
//   - NREQ_DEF    : default number of requesters
//   - DW_DEF      : default byte width
//   - next_ptr()  : round-robin pointer advance with wrap to zero
// No ports (package).
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } arb_state_e;

    // Index that follows idx in a ring of n entries (n-1 wraps to 0).
    function automatic int next_ptr(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// -----------------------------------------------------------------------------
// uart_rr_picker
// Combinational round-robin selector. Scans the valid vector starting at
// i_ptr and wrapping modulo NREQ; reports the first set index.
// Ports:
//   i_valid [NREQ]  : request vector
//   i_ptr   [IW]    : index with highest priority this round
//   o_found         : at least one request is set
//   o_index [IW]    : first set index at or after i_ptr (0 when none)
// -----------------------------------------------------------------------------
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_found,
    output logic [IW-1:0]   o_index
);

    // Walk offsets from farthest to nearest so the entry closest to i_ptr
    // is the last one written and therefore wins.
    always_comb begin
        o_found = 1'b0;
        o_index = {IW{1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            o_found = o_found | i_valid[(int'(i_ptr) + k) % NREQ];
            o_index = i_valid[(int'(i_ptr) + k) % NREQ] ? IW'((int'(i_ptr) + k) % NREQ) : o_index;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin controller sharing one UART transmitter among NREQ byte
// requesters. A byte is captured on grant, handed to the transmitter with a
// one-cycle tx_start, and the arbiter waits for tx_done_tick before the next.
// Optional feature macro: UART_ARB_LOCK_EN -- keep the grant on one requester
// until a byte flagged req_last completes (adds the HOLD state).
// Ports:
//   clk, reset_n      : clock (rising edge), asynchronous active-low reset
//   req_valid [NREQ]  : requester i has a byte pending
//   req_data  [NREQ*DW]: byte of requester i at [i*DW +: DW]
//   req_last  [NREQ]  : byte is the final one of its packet (lock build only)
//   req_ready [NREQ]  : one-hot, one-cycle pulse: byte consumed
//   tx_start          : one-cycle start pulse to the transmitter
//   tx_din    [DW]    : registered byte for the transmitter
//   tx_done_tick      : transmitter finished the stop bit
//   grant_id  [IW]    : current or last granted requester
//   busy              : high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int DW   = DW_DEF,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic             tx_start,
    output logic [DW-1:0]    tx_din,
    input  logic             tx_done_tick,
    output logic [IW-1:0]    grant_id,
    output logic             busy
);

    arb_state_e        r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_grant_id;
    logic [DW-1:0]     r_tx_din;
    logic              r_tx_start;
    logic [NREQ-1:0]   r_req_ready;
    logic              r_busy;
`ifdef UART_ARB_LOCK_EN
    logic              r_last;
`endif

    logic              w_found;
    logic [IW-1:0]     w_index;

    uart_rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_index (w_index)
    );

    // Arbiter FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= {IW{1'b0}};
            r_grant_id  <= {IW{1'b0}};
            r_tx_din    <= {DW{1'b0}};
            r_tx_start  <= 1'b0;
            r_req_ready <= {NREQ{1'b0}};
            r_busy      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            r_last      <= 1'b0;
`endif
        end else begin
            // Start and ready are single-cycle pulses unless re-armed below.
            r_tx_start  <= 1'b0;
            r_req_ready <= {NREQ{1'b0}};
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant_id  <= w_index;
                        r_tx_din    <= req_data[w_index*DW +: DW];
`ifdef UART_ARB_LOCK_EN
                        r_last      <= req_last[w_index];
`endif
                        r_tx_start  <= 1'b1;
                        r_req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << w_index;
                        r_busy      <= 1'b1;
                        r_state     <= SEND;
                    end else begin
                        r_state     <= IDLE;
                    end
                end
                SEND: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (tx_done_tick) begin
`ifdef UART_ARB_LOCK_EN
                        if (!r_last) begin
                            r_state <= HOLD;
                        end else begin
                            r_ptr   <= IW'(next_ptr(int'(r_grant_id), NREQ));
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
`else
                        r_ptr   <= IW'(next_ptr(int'(r_grant_id), NREQ));
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
`endif
                    end else begin
                        r_state <= WAIT;
                    end
                end
`ifdef UART_ARB_LOCK_EN
                HOLD: begin
                    // Only the locked requester may continue its packet.
                    if (req_valid[r_grant_id]) begin
                        r_tx_din    <= req_data[r_grant_id*DW +: DW];
                        r_last      <= req_last[r_grant_id];
                        r_tx_start  <= 1'b1;
                        r_req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << r_grant_id;
                        r_state     <= SEND;
                    end else begin
                        r_state     <= HOLD;
                    end
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign tx_start  = r_tx_start;
    assign tx_din    = r_tx_din;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;

endmodule
